// File: rtl/sequence_player_pkg.sv
// Shared types and defaults for the sequence player: FSM state encoding,
// default symbol and timing widths, and the dwell terminal-count helper.
package sequence_player_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_ON_TICKS  = 5;
    localparam int DEF_OFF_TICKS = 2;
    localparam int TICK_CNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHOW,
        ST_GAP,
        ST_DONE
    } state_t;

    // Count value on which a dwell of n ticks ends; n==0 only occurs for an unused gap phase.
    function automatic logic [TICK_CNT_W-1:0] last_tick(input int n);
        return (n == 0) ? '0 : TICK_CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/sequence_player_dwell_timer.sv
// Tick counter shared by the SHOW and GAP phases: counts enabled ticks,
// clears on request and flags the tick that reaches the terminal count.
module dwell_timer
    import sequence_player_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [TICK_CNT_W-1:0] terminal,
    output logic                  hit
);

    logic [TICK_CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign hit = enable && (count_reg == terminal);

endmodule

// File: rtl/sequence_player.sv
// Plays a stored symbol sequence: fetch, show for ON_TICKS, blank for OFF_TICKS,
// next symbol; gates the upstream timebase so it only runs while timing a phase.
module sequence_player
    import sequence_player_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    output logic              tick_en,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] disp_val,
    output logic              disp_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [TICK_CNT_W-1:0] ON_LAST  = last_tick(ON_TICKS);
    localparam logic [TICK_CNT_W-1:0] OFF_LAST = last_tick(OFF_TICKS);

    state_t              state_reg;
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W:0]     len_reg;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [DATA_W-1:0]   disp_val_reg;
    logic                disp_valid_reg;
    logic                tick_en_reg;
    logic                busy_reg;
    logic                done_reg;

    logic                  in_timed;
    logic                  timer_clear;
    logic                  timer_hit;
    logic                  last_sym;
    logic [TICK_CNT_W-1:0] timer_terminal;

    assign in_timed       = (state_reg == ST_SHOW) || (state_reg == ST_GAP);
    assign timer_terminal = (state_reg == ST_GAP) ? OFF_LAST : ON_LAST;
    assign timer_clear    = (state_reg == ST_LOAD) || timer_hit;
    // len is never 0 outside IDLE, so len-1 cannot underflow where this is used.
    assign last_sym       = ({1'b0, idx_reg} == (len_reg - 1'b1));

    dwell_timer u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (tick && in_timed),
        .terminal (timer_terminal),
        .hit      (timer_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            len_reg        <= '0;
            rd_addr_reg    <= '0;
            disp_val_reg   <= '0;
            disp_valid_reg <= 1'b0;
            tick_en_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (seq_len != '0) begin
                            len_reg   <= seq_len;
                            idx_reg   <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= ST_FETCH;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    rd_addr_reg <= idx_reg;
                    state_reg   <= ST_LOAD;
                end
                ST_LOAD: begin
                    disp_val_reg   <= rd_data;
                    disp_valid_reg <= 1'b1;
                    tick_en_reg    <= 1'b1;
                    state_reg      <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (timer_hit) begin
                        disp_valid_reg <= 1'b0;
                        if (OFF_TICKS != 0) begin
                            state_reg <= ST_GAP;
                        end else begin
                            tick_en_reg <= 1'b0;
                            if (last_sym) begin
                                state_reg <= ST_DONE;
                            end else begin
                                idx_reg   <= idx_reg + 1'b1;
                                state_reg <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (timer_hit) begin
                        tick_en_reg <= 1'b0;
                        if (last_sym) begin
                            state_reg <= ST_DONE;
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            state_reg <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    disp_val_reg <= '0;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr    = rd_addr_reg;
    assign disp_val   = disp_val_reg;
    assign disp_valid = disp_valid_reg;
    assign tick_en    = tick_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule
